instr_mem_ctrl: RTL and testbench
=================================

Name: instr_mem_ctrl

Overview:
- Parametrised, clocked instruction memory for the RISC-V core.
- Replaces the hard-coded, reset-loaded byte array with word storage, a synchronous program-load port and a ready/valid fetch port.
- On reset, sweeps the whole memory to a fill value, so PC fetch never sees X.
- Sits between the PC/fetch stage and the decode stage; the loader (testbench, or a UART/JTAG loader later) owns the load port.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words stored (power of two, ≥4).
- ADDR_W, 32, width of the byte address on the fetch port.
- INIT_CLEAR, 1: 1 = sweep memory after reset; 0 = go straight to READY with contents unchanged.
- FILL_VALUE, 32'h00000013, word written by the sweep and returned on a fault (NOP, addi x0,x0,0).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- fetch_req  in  1  fetch request; address is valid.
- fetch_addr  in  ADDR_W  byte address (the PC).
- fetch_ready  out  1  request accepted this cycle when fetch_req && fetch_ready.
- instr_valid  out  1  instr_data/instr_fault hold a result.
- instr_data  out  32  little-endian instruction word.
- instr_fault  out  1  result is a misaligned or out-of-range fetch.
- out_ready  in  1  decode consumes the result when instr_valid && out_ready.
- load_we  in  1  load-port write strobe.
- load_addr  in  $clog2(DEPTH_WORDS)  word index.
- load_data  in  32  write data.
- load_be  in  4  byte enables; bit i covers bits [8i+7:8i].
- busy  out  1  INIT sweep in progress.

Behaviour:
- Reset (when reset=1 at a clk edge), regardless of state:
  - Outputs: instr_valid=0, instr_data=0, instr_fault=0.
  - Internal: sweep counter=0.
  - State: INIT if INIT_CLEAR=1, else READY.
  - Memory: contents are untouched by reset itself.
- States:
  - INIT:
    - One word per cycle: mem[cnt]<=FILL_VALUE, cnt++.
    - When cnt==DEPTH_WORDS-1 is written, go to READY. Sweep takes exactly DEPTH_WORDS cycles.
    - busy=1, fetch_ready=0, load_we ignored.
  - READY: normal operation, busy=0.
- fetch_ready = (state==READY) && !load_we && (!instr_valid || out_ready).
  - Load has priority over fetch.
  - A stalled output blocks new requests.
- Accepted fetch gives a result on the next edge (1-cycle latency): instr_valid<=1.
  - Misaligned (fetch_addr[1:0]!=0) or out of range (fetch_addr ≥ 4*DEPTH_WORDS): instr_fault<=1, instr_data<=FILL_VALUE.
  - Otherwise: instr_fault<=0, instr_data<=mem[fetch_addr[..:2]].
- Result register:
  - Holds its value while instr_valid && !out_ready.
  - Clears instr_valid when consumed with no new accept in the same cycle.
  - Back-to-back accepts give one result per cycle.
- Load write (READY, load_we=1): only the bytes with load_be set are updated; load_be=0 is a no-op cycle that still blocks fetch.
- Read-during-write to the same word cannot happen (fetch is blocked by load_we). A result already held in the output register keeps its old value.
- Arithmetic: word index = fetch_addr >> 2. The range check uses the full ADDR_W address, with no wrap-around.

Decomposition:
- Shared package rv_mem_pkg:
  - NOP_INSTR constant (32'h00000013).
  - State typedef {INIT, READY}.
  - Byte-enable width constant (4).
- One sub-module, instr_mem_array: single-port word RAM with byte-enable write and combinational read, parametrised by depth.
- The sweep FSM, arbitration and output register stay in instr_mem_ctrl.

Test Plan:
- Sweep: reset 1 cycle with DEPTH_WORDS=64, INIT_CLEAR=1 → busy=1 for exactly 64 cycles, fetch_ready=0 throughout. Then fetch 0x3C → instr_data=0x00000013, fault=0.
- Load then fetch: load word 3 = 0x02208 0b3 (be=4'hF) and word 4 = 0x00308463; fetch 0x0C, 0x10 back-to-back with out_ready=1 → consecutive results 0x022080b3, 0x00308463, one cycle after each accept.
- Byte enables: word 5 = 0xAABBCCDD, then write 0x11223344 with be=4'b0101 → fetch 0x14 returns 0xAA22CC44.
- Faults: fetch 0x0000000E → fault=1, data=0x00000013. Fetch 0x100 with DEPTH_WORDS=64 → fault=1, data=0x00000013.
- Backpressure and priority:
  - Hold out_ready=0 with a result valid → data stable, fetch_ready=0.
  - Assert load_we together with fetch_req → load happens, fetch not accepted until load_we drops.
- Reset mid-operation: assert reset during sweep cnt=20 and again while a result is stalled → instr_valid=0 next cycle, sweep restarts at 0 and runs the full 64 cycles.

Source files
------------

// File: rtl/instr_mem_ctrl_pkg.sv
// Shared constants and types for the instruction memory slice.
// Imported by the interface, the RAM and the controller.
package rv_mem_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam int          BE_W      = 4;

   typedef logic [0:0] state_t;

   localparam state_t ST_INIT  = 1'b0;
   localparam state_t ST_READY = 1'b1;

endpackage

// File: rtl/instr_mem_ctrl_if.sv
// Fetch, result and load-port bundle between core, loader and imem.
// The master side is the core/loader; the slave side is the memory.
interface instr_mem_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int LA_W   = 6
);
   import rv_mem_pkg::*;

   logic              fetch_req;
   logic [ADDR_W-1:0] fetch_addr;
   logic              fetch_ready;
   logic              instr_valid;
   logic [31:0]       instr_data;
   logic              instr_fault;
   logic              out_ready;
   logic              load_we;
   logic [LA_W-1:0]   load_addr;
   logic [31:0]       load_data;
   logic [BE_W-1:0]   load_be;
   logic              busy;

   modport master (
      output fetch_req, fetch_addr, out_ready,
      output load_we, load_addr, load_data, load_be,
      input  fetch_ready, instr_valid, instr_data,
      input  instr_fault, busy
   );

   modport slave (
      input  fetch_req, fetch_addr, out_ready,
      input  load_we, load_addr, load_data, load_be,
      output fetch_ready, instr_valid, instr_data,
      output instr_fault, busy
   );

endinterface

// File: rtl/instr_mem_array.sv
// Single-port word RAM: byte-enable write, combinational read.
// Read and write share one address; the controller arbitrates.
module instr_mem_array
   import rv_mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 64,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic            clk,
   input  logic            we,
   input  logic [AW-1:0]   addr,
   input  logic [31:0]     wdata,
   input  logic [BE_W-1:0] be,
   output logic [31:0]     rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < BE_W; i++) begin
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/instr_mem_ctrl.sv
// Instruction memory controller: reset sweep, load/fetch arbitration
// and a one-entry result register toward decode.
module instr_mem_ctrl
   import rv_mem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 64,
   parameter int          ADDR_W      = 32,
   parameter int          INIT_CLEAR  = 1,
   parameter logic [31:0] FILL_VALUE  = NOP_INSTR
) (
   input logic              clk,
   input logic              reset,
   instr_mem_ctrl_if.slave  bus
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(4 * DEPTH_WORDS);

   state_t          state;
   logic [AW-1:0]   cnt;
   logic            valid_q;
   logic            fault_q;
   logic [31:0]     data_q;

   logic            in_init;
   logic            accept;
   logic            bad;
   logic            mem_we;
   logic [AW-1:0]   mem_addr;
   logic [31:0]     mem_wdata;
   logic [31:0]     mem_rdata;
   logic [BE_W-1:0] mem_be;

   assign in_init = (state == ST_INIT);

   assign bus.busy        = in_init;
   assign bus.fetch_ready = !in_init && !bus.load_we &&
                            (!valid_q || bus.out_ready);
   assign bus.instr_valid = valid_q;
   assign bus.instr_data  = data_q;
   assign bus.instr_fault = fault_q;

   assign accept = bus.fetch_req && bus.fetch_ready;

   // Full-width compare so high PCs never alias onto low words
   assign bad = (bus.fetch_addr[1:0] != 2'b00) ||
                (bus.fetch_addr >= LIMIT);

   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = bus.fetch_addr[AW+1:2];
      mem_wdata = bus.load_data;
      mem_be    = bus.load_be;
      if (in_init) begin
         mem_we    = 1'b1;
         mem_addr  = cnt;
         mem_wdata = FILL_VALUE;
         mem_be    = '1;
      end else if (bus.load_we) begin
         mem_we   = 1'b1;
         mem_addr = bus.load_addr;
      end
   end

   instr_mem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_array (
      .clk   (clk),
      .we    (mem_we),
      .addr  (mem_addr),
      .wdata (mem_wdata),
      .be    (mem_be),
      .rdata (mem_rdata)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= (INIT_CLEAR != 0) ? ST_INIT : ST_READY;
         cnt     <= '0;
         valid_q <= 1'b0;
         fault_q <= 1'b0;
         data_q  <= '0;
      end else if (in_init) begin
         cnt <= cnt + 1'b1;
         if (cnt == AW'(DEPTH_WORDS - 1)) state <= ST_READY;
      end else if (accept) begin
         valid_q <= 1'b1;
         fault_q <= bad;
         data_q  <= bad ? FILL_VALUE : mem_rdata;
      end else if (bus.out_ready) begin
         valid_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Self-checking bench for instr_mem_ctrl: directed scenarios plus a
// randomized run against a word-array reference model.
module tb_instr_mem_ctrl;
   import rv_mem_pkg::*;

   localparam int DEPTH = 64;
   localparam int AW    = 6;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   instr_mem_ctrl_if #(.ADDR_W(32), .LA_W(AW)) bus ();

   instr_mem_ctrl #(
      .DEPTH_WORDS (DEPTH),
      .ADDR_W      (32),
      .INIT_CLEAR  (1),
      .FILL_VALUE  (NOP_INSTR)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int tests = 0;
   int fails = 0;
   logic [31:0] mm [DEPTH];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      bus.fetch_req  = 1'b0;
      bus.fetch_addr = '0;
      bus.out_ready  = 1'b1;
      bus.load_we    = 1'b0;
      bus.load_addr  = '0;
      bus.load_data  = '0;
      bus.load_be    = '0;
   endtask

   task automatic sweep_len(output int n, output int fr_bad);
      n = 0;
      fr_bad = 0;
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 32'h0;
      while (bus.busy === 1'b1 && n < 200) begin
         #1;
         if (bus.fetch_ready !== 1'b0) fr_bad++;
         @(posedge clk);
         #1;
         n++;
      end
      bus.fetch_req = 1'b0;
      for (int i = 0; i < DEPTH; i++) mm[i] = NOP_INSTR;
   endtask

   task automatic load_word(input logic [AW-1:0] a, input logic [31:0] d,
                            input logic [3:0] be);
      bus.load_we   = 1'b1;
      bus.load_addr = a;
      bus.load_data = d;
      bus.load_be   = be;
      for (int i = 0; i < 4; i++) if (be[i]) mm[a][8*i +: 8] = d[8*i +: 8];
      tick();
      bus.load_we = 1'b0;
      bus.load_be = '0;
   endtask

   task automatic fetch_one(input logic [31:0] a, output logic rdy,
                            output logic v, output logic [31:0] d,
                            output logic f);
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = a;
      #1;
      rdy = bus.fetch_ready;
      tick();
      bus.fetch_req = 1'b0;
      v = bus.instr_valid;
      d = bus.instr_data;
      f = bus.instr_fault;
   endtask

   task automatic test_reset;
      int n, fb;
      reset = 1'b1;
      idle();
      tick();
      reset = 1'b0;
      tests++;
      if ({bus.instr_valid, bus.instr_fault} !== 2'b00 ||
          bus.instr_data !== 32'h0) begin
         fails++;
         $display("FAIL reset_outputs: got v=%b f=%b d=%h want 0 0 0",
                  bus.instr_valid, bus.instr_fault, bus.instr_data);
      end
      sweep_len(n, fb);
      tests++;
      if (n !== DEPTH) begin
         fails++;
         $display("FAIL sweep_len: got %0d want %0d", n, DEPTH);
      end
      tests++;
      if (fb !== 0) begin
         fails++;
         $display("FAIL sweep_fetch_ready: %0d cycles ready, want 0", fb);
      end
   endtask

   task automatic test_sweep_fill;
      logic r, v, f;
      logic [31:0] d;
      fetch_one(32'h3C, r, v, d, f);
      tests++;
      if (r !== 1'b1 || v !== 1'b1 || f !== 1'b0 || d !== 32'h13) begin
         fails++;
         $display("FAIL sweep_fill: got r=%b v=%b f=%b d=%h want 1 1 0 00000013",
                  r, v, f, d);
      end
   endtask

   task automatic test_load_fetch;
      load_word(6'd3, 32'h022080b3, 4'hF);
      load_word(6'd4, 32'h00308463, 4'hF);
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 32'h0C;
      tick();
      tests++;
      if (bus.instr_valid !== 1'b1 || bus.instr_data !== 32'h022080b3) begin
         fails++;
         $display("FAIL b2b_first: got v=%b d=%h want 1 022080b3",
                  bus.instr_valid, bus.instr_data);
      end
      bus.fetch_addr = 32'h10;
      tick();
      tests++;
      if (bus.instr_valid !== 1'b1 || bus.instr_data !== 32'h00308463) begin
         fails++;
         $display("FAIL b2b_second: got v=%b d=%h want 1 00308463",
                  bus.instr_valid, bus.instr_data);
      end
      bus.fetch_req = 1'b0;
      tick();
      tests++;
      if (bus.instr_valid !== 1'b0) begin
         fails++;
         $display("FAIL b2b_drain: got v=%b want 0", bus.instr_valid);
      end
   endtask

   task automatic test_byte_enable;
      logic r, v, f;
      logic [31:0] d;
      load_word(6'd5, 32'hAABBCCDD, 4'hF);
      load_word(6'd5, 32'h11223344, 4'b0101);
      fetch_one(32'h14, r, v, d, f);
      tests++;
      if (v !== 1'b1 || f !== 1'b0 || d !== 32'hAA22CC44) begin
         fails++;
         $display("FAIL byte_enable: got v=%b f=%b d=%h want 1 0 aa22cc44",
                  v, f, d);
      end
   endtask

   task automatic test_faults;
      logic [31:0] addrs [4];
      logic        expf  [4];
      logic r, v, f;
      logic [31:0] d;
      addrs = '{32'h0000000E, 32'h00000100, 32'h000000FC, 32'hFFFFFFFC};
      expf  = '{1'b1, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
         fetch_one(addrs[i], r, v, d, f);
         tests++;
         if (v !== 1'b1 || f !== expf[i] || d !== 32'h13) begin
            fails++;
            $display("FAIL fault_%h: got v=%b f=%b d=%h want 1 %b 00000013",
                     addrs[i], v, f, d, expf[i]);
         end
      end
      tick();
   endtask

   task automatic test_backpressure;
      int bad;
      bus.out_ready  = 1'b0;
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 32'h0C;
      tick();
      bus.fetch_addr = 32'h10;
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         if (bus.fetch_ready !== 1'b0 || bus.instr_valid !== 1'b1 ||
             bus.instr_data !== 32'h022080b3) bad++;
         tick();
      end
      tests++;
      if (bad !== 0) begin
         fails++;
         $display("FAIL stall_hold: %0d bad cycles, d=%h want 0 022080b3",
                  bad, bus.instr_data);
      end
      bus.out_ready = 1'b1;
      #1;
      tests++;
      if (bus.fetch_ready !== 1'b1) begin
         fails++;
         $display("FAIL stall_release: got ready=%b want 1", bus.fetch_ready);
      end
      tick();
      bus.fetch_req = 1'b0;
      tests++;
      if (bus.instr_data !== 32'h00308463) begin
         fails++;
         $display("FAIL stall_next: got %h want 00308463", bus.instr_data);
      end
      tick();
   endtask

   task automatic test_priority;
      logic r, v, f;
      logic [31:0] d;
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 32'h14;
      bus.load_we    = 1'b1;
      bus.load_addr  = 6'd6;
      bus.load_data  = 32'hDEADBEEF;
      bus.load_be    = 4'hF;
      mm[6] = 32'hDEADBEEF;
      #1;
      tests++;
      if (bus.fetch_ready !== 1'b0) begin
         fails++;
         $display("FAIL prio_block: got ready=%b want 0", bus.fetch_ready);
      end
      tick();
      tests++;
      if (bus.instr_valid !== 1'b0) begin
         fails++;
         $display("FAIL prio_noaccept: got v=%b want 0", bus.instr_valid);
      end
      bus.load_we = 1'b0;
      bus.load_be = '0;
      fetch_one(32'h14, r, v, d, f);
      tests++;
      if (r !== 1'b1 || d !== 32'hAA22CC44) begin
         fails++;
         $display("FAIL prio_after: got r=%b d=%h want 1 aa22cc44", r, d);
      end
      fetch_one(32'h18, r, v, d, f);
      tests++;
      if (d !== 32'hDEADBEEF || f !== 1'b0) begin
         fails++;
         $display("FAIL prio_loaded: got f=%b d=%h want 0 deadbeef", f, d);
      end
      tick();
   endtask

   task automatic test_random;
      logic        ev, ef, er;
      logic [31:0] ed, a, wd;
      logic [3:0]  be;
      logic [AW-1:0] la;
      int sel;
      ev = 1'b0;
      ef = 1'b0;
      ed = '0;
      for (int c = 0; c < 400; c++) begin
         sel = $urandom_range(0, 9);
         if (sel < 7)       a = {24'h0, $urandom_range(0, 63), 2'b00};
         else if (sel == 7) a = $urandom_range(0, 255) | 32'h1;
         else if (sel == 8) a = 32'h100 + 4 * $urandom_range(0, 63);
         else               a = $urandom;
         la = AW'($urandom_range(0, 63));
         wd = $urandom;
         be = 4'($urandom_range(0, 15));
         bus.fetch_req  = ($urandom_range(0, 3) != 0);
         bus.fetch_addr = a;
         bus.out_ready  = ($urandom_range(0, 3) != 0);
         bus.load_we    = ($urandom_range(0, 4) == 0);
         bus.load_addr  = la;
         bus.load_data  = wd;
         bus.load_be    = be;
         #1;
         er = !bus.load_we && (!ev || bus.out_ready);
         tests++;
         if (bus.fetch_ready !== er) begin
            fails++;
            $display("FAIL rnd_ready c=%0d: got %b want %b",
                     c, bus.fetch_ready, er);
         end
         if (bus.fetch_req && er) begin
            ev = 1'b1;
            ef = (a % 4 != 0) || (a >= 32'd256);
            ed = ef ? NOP_INSTR : mm[a / 4];
         end else if (bus.out_ready) begin
            ev = 1'b0;
         end
         if (bus.load_we) begin
            for (int i = 0; i < 4; i++)
               if (be[i]) mm[la][8*i +: 8] = wd[8*i +: 8];
         end
         tick();
         tests++;
         if (bus.instr_valid !== ev ||
             (ev && (bus.instr_data !== ed || bus.instr_fault !== ef))) begin
            fails++;
            $display("FAIL rnd_result c=%0d: got v=%b f=%b d=%h want %b %b %h",
                     c, bus.instr_valid, bus.instr_fault, bus.instr_data,
                     ev, ef, ed);
         end
      end
      idle();
      tick();
   endtask

   task automatic test_reset_mid;
      int n, fb;
      logic r, v, f;
      logic [31:0] d;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      repeat (20) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      sweep_len(n, fb);
      tests++;
      if (n !== DEPTH || fb !== 0) begin
         fails++;
         $display("FAIL midsweep_reset: got len=%0d rdy=%0d want %0d 0",
                  n, fb, DEPTH);
      end
      fetch_one(32'h18, r, v, d, f);
      tests++;
      if (d !== NOP_INSTR) begin
         fails++;
         $display("FAIL resweep_fill: got %h want 00000013", d);
      end
      bus.out_ready = 1'b0;
      fetch_one(32'h0, r, v, d, f);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tests++;
      if (bus.instr_valid !== 1'b0 || bus.instr_data !== 32'h0 ||
          bus.busy !== 1'b1) begin
         fails++;
         $display("FAIL stall_reset: got v=%b d=%h busy=%b want 0 0 1",
                  bus.instr_valid, bus.instr_data, bus.busy);
      end
      bus.out_ready = 1'b1;
      sweep_len(n, fb);
      tests++;
      if (n !== DEPTH) begin
         fails++;
         $display("FAIL stall_resweep: got %0d want %0d", n, DEPTH);
      end
   endtask

   initial begin
      test_reset();
      test_sweep_fill();
      test_load_fetch();
      test_byte_enable();
      test_faults();
      test_backpressure();
      test_priority();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
